// File: rtl/masked_hpc3_chain_ctrl.sv
// Issue/credit sequencer for a chained pair of masked HPC3 multipliers.
// Issues an op only when operands, fresh randomness and a result-buffer slot are all available.
module masked_hpc3_chain_ctrl #(
    parameter  int LATENCY     = 2,
    parameter  int DEPTH       = 4,
    parameter  int COUNT_WIDTH = 16,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    input  logic                   in_enable,
    input  logic                   in_flush,
    input  logic                   in_op_valid,
    output logic                   out_op_ready,
    input  logic                   in_rand_valid,
    output logic                   out_rand_ready,
    output logic                   out_cb_rand_load,
    output logic [LATENCY-1:0]     out_stage_valid,
    output logic                   out_buf_wr_en,
    output logic [ADDR_W-1:0]      out_buf_wr_addr,
    output logic [ADDR_W-1:0]      out_buf_rd_addr,
    output logic                   out_res_valid,
    input  logic                   in_res_ready,
    output logic                   out_busy,
    output logic [COUNT_WIDTH-1:0] out_op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_CREDITS = (ADDR_W+1)'(DEPTH);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LATENCY-1:0]     r_vld_pipe;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic [ADDR_W:0]        r_count;
    logic [ADDR_W:0]        r_credits;
    logic [COUNT_WIDTH-1:0] r_op_count;

    logic w_run;
    logic w_has_credit;
    logic w_issue;
    logic w_pipe_empty;
    logic w_write;
    logic w_res_valid;
    logic w_pop;
    logic w_flush_exit;

    // Both handshake channels depend on the other side's valid so they always fire as a pair.
    always_comb begin
        w_run        = (r_state == S_RUN);
        w_has_credit = (r_credits != '0);
        w_issue      = w_run & w_has_credit & in_op_valid & in_rand_valid;
        w_pipe_empty = (r_vld_pipe == '0);
        w_write      = r_vld_pipe[LATENCY-1] & (r_state != S_FLUSH);
        w_res_valid  = (r_count != '0) & (r_state != S_FLUSH);
        w_pop        = w_res_valid & in_res_ready;
        w_flush_exit = (r_state == S_FLUSH) & (w_state_nxt == S_IDLE);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (in_flush) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE:  if (in_enable) w_state_nxt = S_RUN;
                S_RUN:   if (!in_enable) w_state_nxt = S_DRAIN;
                S_DRAIN: begin
                    if (in_enable)         w_state_nxt = S_RUN;
                    else if (w_pipe_empty) w_state_nxt = S_IDLE;
                end
                S_FLUSH: if (w_pipe_empty) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // In-flight ops keep moving during a flush; only their buffer writes are dropped.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_issue;
            for (int i = 1; i < LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_count    <= '0;
            r_credits  <= FULL_CREDITS;
            r_op_count <= '0;
        end else if (w_flush_exit) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_count    <= '0;
            r_credits  <= FULL_CREDITS;
            r_op_count <= '0;
        end else begin
            if (w_write) r_wr_addr <= r_wr_addr + ADDR_W'(1);
            if (w_pop)   r_rd_addr <= r_rd_addr + ADDR_W'(1);
            if (w_issue) r_op_count <= r_op_count + COUNT_WIDTH'(1);

            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase

            // A credit leaves with each issue and returns when its result is popped.
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - (ADDR_W+1)'(1);
                2'b01:   r_credits <= r_credits + (ADDR_W+1)'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_comb begin
        out_op_ready     = w_run & w_has_credit & in_rand_valid;
        out_rand_ready   = w_run & w_has_credit & in_op_valid;
        out_cb_rand_load = w_issue;
        out_stage_valid  = r_vld_pipe;
        out_buf_wr_en    = w_write;
        out_buf_wr_addr  = r_wr_addr;
        out_buf_rd_addr  = r_rd_addr;
        out_res_valid    = w_res_valid;
        out_busy         = (r_state != S_IDLE) | ~w_pipe_empty;
        out_op_count     = r_op_count;
    end

endmodule

// File: tb/tb_masked_hpc3_chain_ctrl.sv
// Directed bench for masked_hpc3_chain_ctrl; a tag scoreboard tracks issue -> write -> pop order and latency.
module tb_masked_hpc3_chain_ctrl;

    localparam int LAT = 2;
    localparam int DEP = 4;
    localparam int CW  = 3;
    localparam int AW  = 2;

    logic          in_clock = 1'b0;
    logic          in_reset = 1'b1;
    logic          in_enable = 1'b0;
    logic          in_flush = 1'b0;
    logic          in_op_valid = 1'b0;
    logic          in_rand_valid = 1'b0;
    logic          in_res_ready = 1'b0;
    logic          out_op_ready;
    logic          out_rand_ready;
    logic          out_cb_rand_load;
    logic [LAT-1:0] out_stage_valid;
    logic          out_buf_wr_en;
    logic [AW-1:0] out_buf_wr_addr;
    logic [AW-1:0] out_buf_rd_addr;
    logic          out_res_valid;
    logic          out_busy;
    logic [CW-1:0] out_op_count;

    masked_hpc3_chain_ctrl #(.LATENCY(LAT), .DEPTH(DEP), .COUNT_WIDTH(CW)) dut (
        .in_clock        (in_clock),
        .in_reset        (in_reset),
        .in_enable       (in_enable),
        .in_flush        (in_flush),
        .in_op_valid     (in_op_valid),
        .out_op_ready    (out_op_ready),
        .in_rand_valid   (in_rand_valid),
        .out_rand_ready  (out_rand_ready),
        .out_cb_rand_load(out_cb_rand_load),
        .out_stage_valid (out_stage_valid),
        .out_buf_wr_en   (out_buf_wr_en),
        .out_buf_wr_addr (out_buf_wr_addr),
        .out_buf_rd_addr (out_buf_rd_addr),
        .out_res_valid   (out_res_valid),
        .in_res_ready    (in_res_ready),
        .out_busy        (out_busy),
        .out_op_count    (out_op_count)
    );

    always #5 in_clock = ~in_clock;

    typedef struct {
        int tag;
        int icyc;
    } fl_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  tag_seq  = 0;
    fl_t inflight[$];
    int  expq[$];
    int  tbmem[DEP];
    fl_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clock);
        #2;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        in_res_ready = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (!out_res_valid && out_stage_valid == '0) done = 1'b1;
            else tick();
        end
        chk("drain_done", done, 1);
        in_res_ready = 1'b0;
    endtask

    always @(posedge in_clock) cyc <= cyc + 1;

    // Scoreboard: issues push a tag; writes must land LAT cycles later; pops must return tags in order.
    always @(negedge in_clock) begin
        if (in_reset) begin
            if (out_buf_wr_en) begin
                if (inflight.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    mon_e = inflight.pop_front();
                    chk("wr_latency", cyc, mon_e.icyc + LAT);
                    tbmem[out_buf_wr_addr] = mon_e.tag;
                    expq.push_back(mon_e.tag);
                end
            end
            if (out_res_valid && in_res_ready) begin
                if (expq.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("pop_order", tbmem[out_buf_rd_addr], expq.pop_front());
            end
            if (out_cb_rand_load) begin
                chk("issue_pair", {out_op_ready, out_rand_ready}, 2'b11);
                inflight.push_back('{tag: tag_seq, icyc: cyc});
                tag_seq++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 in_reset = 1'b0;
        #1;
        chk("rst_outputs", {out_op_ready, out_rand_ready, out_cb_rand_load, out_stage_valid, out_buf_wr_en,
                            out_buf_wr_addr, out_buf_rd_addr, out_res_valid, out_busy, out_op_count}, 0);
        repeat (3) tick();
        in_reset = 1'b1;
        tick();
        chk("idle_busy", out_busy, 0);
        in_enable = 1'b1;
        tick();
        chk("run_busy", out_busy, 1);

        // No randomness: no issue
        in_op_valid = 1'b1;
        #1;
        chk("norand_op_ready", out_op_ready, 0);
        chk("norand_rand_ready", out_rand_ready, 1);
        chk("norand_cb_load", out_cb_rand_load, 0);
        tick();
        chk("norand_stages", out_stage_valid, 0);
        chk("norand_op_count", out_op_count, 0);

        // Back-to-back issue until the buffer is full
        in_rand_valid = 1'b1;
        #1;
        chk("b2b_ready_first", out_op_ready, 1);
        repeat (4) tick();
        chk("b2b_ready_full", out_op_ready, 0);
        chk("b2b_no_issue", out_cb_rand_load, 0);
        chk("b2b_op_count", out_op_count, 4);
        repeat (2) tick();
        chk("full_res_valid", out_res_valid, 1);
        chk("full_wr_wrap", out_buf_wr_addr, 0);
        chk("full_rd_addr", out_buf_rd_addr, 0);
        chk("full_stages", out_stage_valid, 0);

        // Pop frees a slot, then pop+issue together, then issue refills
        in_res_ready = 1'b1;
        #1;
        chk("full_blocked", out_op_ready, 0);
        tick();
        chk("pop_frees_credit", out_op_ready, 1);
        chk("pop_rd_addr1", out_buf_rd_addr, 1);
        tick();
        chk("popissue_ready", out_op_ready, 1);
        chk("popissue_rd_addr2", out_buf_rd_addr, 2);
        in_res_ready = 1'b0;
        #1;
        chk("refill_issue", out_cb_rand_load, 1);
        tick();
        chk("refill_full", out_op_ready, 0);
        in_op_valid   = 1'b0;
        in_rand_valid = 1'b0;
        drain();
        chk("drain_inflight_empty", inflight.size(), 0);
        chk("drain_expq_empty", expq.size(), 0);
        chk("drain_op_count", out_op_count, 6);
        chk("drain_wr_addr", out_buf_wr_addr, 2);
        chk("drain_rd_addr", out_buf_rd_addr, 2);

        // Single op latency, with enable dropped to exercise DRAIN
        in_op_valid   = 1'b1;
        in_rand_valid = 1'b1;
        #1;
        chk("single_cb_load", out_cb_rand_load, 1);
        tick();
        in_op_valid   = 1'b0;
        in_rand_valid = 1'b0;
        in_enable     = 1'b0;
        #1;
        chk("single_stage0", out_stage_valid, 2'b01);
        chk("single_no_wr_yet", out_buf_wr_en, 0);
        tick();
        chk("single_stage1", out_stage_valid, 2'b10);
        chk("single_wr_en", out_buf_wr_en, 1);
        chk("single_wr_addr", out_buf_wr_addr, 2);
        chk("single_no_bypass", out_res_valid, 0);
        tick();
        chk("single_res_valid", out_res_valid, 1);
        chk("single_rd_addr", out_buf_rd_addr, 2);
        chk("single_wr_addr_next", out_buf_wr_addr, 3);
        chk("single_op_count", out_op_count, 7);
        chk("drain_busy", out_busy, 1);
        in_res_ready = 1'b1;
        tick();
        chk("single_popped", out_res_valid, 0);
        chk("drain_to_idle", out_busy, 0);
        in_res_ready = 1'b0;
        in_enable    = 1'b1;
        tick();

        // Flush with two ops in flight and two buffered; op_count also wraps here
        in_op_valid   = 1'b1;
        in_rand_valid = 1'b1;
        tick();
        chk("op_count_wrap", out_op_count, 0);
        repeat (2) tick();
        in_flush = 1'b1;
        #1;
        chk("flush_last_issue", out_cb_rand_load, 1);
        tick();
        chk("flush_stages", out_stage_valid, 2'b11);
        chk("flush_no_wr", out_buf_wr_en, 0);
        chk("flush_res_valid", out_res_valid, 0);
        chk("flush_no_issue", {out_op_ready, out_cb_rand_load}, 0);
        chk("flush_op_count", out_op_count, 3);
        in_flush      = 1'b0;
        in_enable     = 1'b0;
        in_op_valid   = 1'b0;
        in_rand_valid = 1'b0;
        in_res_ready  = 1'b1;
        tick();
        chk("flush_no_wr2", out_buf_wr_en, 0);
        chk("flush_res_valid2", out_res_valid, 0);
        chk("flush_busy", out_busy, 1);
        repeat (2) tick();
        chk("flush_idle", out_busy, 0);
        chk("flush_wr_addr", out_buf_wr_addr, 0);
        chk("flush_rd_addr", out_buf_rd_addr, 0);
        chk("flush_op_count_clr", out_op_count, 0);
        chk("flush_empty", out_res_valid, 0);
        in_res_ready = 1'b0;
        inflight.delete();
        expq.delete();

        // Reset mid-operation; full credits are visible by four issues after flush
        in_enable = 1'b1;
        tick();
        in_op_valid   = 1'b1;
        in_rand_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("postflush_credit", out_op_ready, 1);
            tick();
        end
        in_op_valid   = 1'b0;
        in_rand_valid = 1'b0;
        #1;
        chk("prerst_stages", out_stage_valid, 2'b11);
        chk("prerst_res_valid", out_res_valid, 1);
        in_reset = 1'b0;
        #1;
        chk("midrst_outputs", {out_op_ready, out_rand_ready, out_cb_rand_load, out_stage_valid, out_buf_wr_en,
                               out_buf_wr_addr, out_buf_rd_addr, out_res_valid, out_busy, out_op_count}, 0);
        inflight.delete();
        expq.delete();
        tick();
        in_reset = 1'b1;
        tick();
        in_op_valid   = 1'b1;
        in_rand_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("postrst_credit", out_op_ready, 1);
            tick();
        end
        #1;
        chk("postrst_full", out_op_ready, 0);
        in_op_valid   = 1'b0;
        in_rand_valid = 1'b0;
        drain();
        chk("final_inflight_empty", inflight.size(), 0);
        chk("final_expq_empty", expq.size(), 0);
        chk("final_op_count", out_op_count, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
